// File: rtl/sym_vn_lut_pingpong_pkg.sv
// Shared types for the double-buffered symmetric VN LUT.
// Holds the loader FSM encoding and the bank-select width rule.
package sym_vn_lut_pingpong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    // A single bank still needs a one-bit select so port vectors never collapse to zero width.
    function automatic int bsel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sym_vn_lut_bank.sv
// One LUT bank: two pages, a single write port and
// READ_PORT_NUM asynchronous read ports on the selected page.
module sym_vn_lut_bank #(
    parameter int QUAN_SIZE     = 3,
    parameter int ENTRY_ADDR    = 5,
    parameter int READ_PORT_NUM = 4
) (
    input  logic                              i_clk,
    input  logic                              i_we,
    input  logic                              i_wpage,
    input  logic [ENTRY_ADDR-1:0]             i_waddr,
    input  logic [QUAN_SIZE-1:0]              i_wdata,
    input  logic                              i_rpage,
    input  logic [READ_PORT_NUM*ENTRY_ADDR-1:0] i_raddr,
    output logic [READ_PORT_NUM*QUAN_SIZE-1:0]  o_rdata
);

    localparam int DEPTH = 2 ** (ENTRY_ADDR + 1);

    // Page bit is the MSB of the physical address.
    logic [QUAN_SIZE-1:0] r_mem [DEPTH];

    // Loader write into the shadow page; contents are never reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[{i_wpage, i_waddr}] <= i_wdata;
        end
    end

    // Independent combinational reads of the active page.
    always_comb begin
        o_rdata = '0;
        for (int p = 0; p < READ_PORT_NUM; p++) begin
            o_rdata[p*QUAN_SIZE +: QUAN_SIZE] =
                r_mem[{i_rpage, i_raddr[p*ENTRY_ADDR +: ENTRY_ADDR]}];
        end
    end

endmodule

// File: rtl/sym_vn_lut_pingpong.sv
// Double-buffered symmetric VN LUT: banks with active/shadow pages,
// a streaming shadow loader and an iteration-boundary page swap.
module sym_vn_lut_pingpong
    import sym_vn_lut_pingpong_pkg::*;
#(
    parameter int QUAN_SIZE     = 3,
    parameter int ENTRY_ADDR    = 5,
    parameter int BANK_NUM      = 2,
    parameter int READ_PORT_NUM = 4,
    parameter int BSEL_W        = bsel_width(BANK_NUM)
) (
    input  logic                                i_write_clk,
    input  logic                                i_rst,
    input  logic                                i_load_start,
    input  logic                                i_load_valid,
    output logic                                o_load_ready,
    input  logic [BANK_NUM*QUAN_SIZE-1:0]       i_load_data,
    output logic                                o_load_done,
    input  logic                                i_swap_req,
    output logic                                o_swap_ack,
    output logic                                o_active_page,
    input  logic [READ_PORT_NUM*BSEL_W-1:0]     i_rd_bank,
    input  logic [READ_PORT_NUM*ENTRY_ADDR-1:0] i_rd_addr,
    output logic [READ_PORT_NUM*QUAN_SIZE-1:0]  o_rd_data
);

    localparam logic [ENTRY_ADDR-1:0] LAST_ADDR = '1;

    state_t                            r_state;
    state_t                            w_state_nxt;
    logic [ENTRY_ADDR-1:0]             r_cnt;
    logic                              r_active_page;
    logic                              r_swap_ack;
    logic [READ_PORT_NUM*QUAN_SIZE-1:0] r_rd_data;
    logic [READ_PORT_NUM*QUAN_SIZE-1:0] w_rd_data;
    logic [READ_PORT_NUM*QUAN_SIZE-1:0] w_bank_rd [BANK_NUM];
    logic                              w_beat;
    logic                              w_swap;
    logic                              w_shadow_page;

    assign w_shadow_page = ~r_active_page;
    assign o_load_ready  = (r_state == ST_LOAD);
    assign o_load_done   = (r_state == ST_FULL);
    assign o_swap_ack    = r_swap_ack;
    assign o_active_page = r_active_page;
    assign o_rd_data     = r_rd_data;

    // Loader next-state: accept beats in LOAD, swap only once the shadow page is full.
    always_comb begin
        w_state_nxt = r_state;
        w_beat      = 1'b0;
        w_swap      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_load_start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (i_load_valid) begin
                    w_beat = 1'b1;
                    if (r_cnt == LAST_ADDR) begin
                        w_state_nxt = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                if (i_swap_req) begin
                    w_swap      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state, swap acknowledge pulse and page pointer.
    always_ff @(posedge i_write_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_swap_ack    <= 1'b0;
            r_active_page <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_swap_ack <= w_swap;
            if (w_swap) begin
                r_active_page <= ~r_active_page;
            end
        end
    end

    // Shadow-page write address: cleared on a fresh load, advanced per beat.
    always_ff @(posedge i_write_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if ((r_state == ST_IDLE) && i_load_start) begin
            r_cnt <= '0;
        end else if (w_beat) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
        sym_vn_lut_bank #(
            .QUAN_SIZE     (QUAN_SIZE),
            .ENTRY_ADDR    (ENTRY_ADDR),
            .READ_PORT_NUM (READ_PORT_NUM)
        ) u_bank (
            .i_clk   (i_write_clk),
            .i_we    (w_beat),
            .i_wpage (w_shadow_page),
            .i_waddr (r_cnt),
            .i_wdata (i_load_data[b*QUAN_SIZE +: QUAN_SIZE]),
            .i_rpage (r_active_page),
            .i_raddr (i_rd_addr),
            .o_rdata (w_bank_rd[b])
        );
    end

    // Per-port bank mux; a select past the last bank matches nothing and reads 0.
    always_comb begin
        w_rd_data = '0;
        for (int p = 0; p < READ_PORT_NUM; p++) begin
            for (int b = 0; b < BANK_NUM; b++) begin
                if (i_rd_bank[p*BSEL_W +: BSEL_W] == BSEL_W'(b)) begin
                    w_rd_data[p*QUAN_SIZE +: QUAN_SIZE] =
                        w_bank_rd[b][p*QUAN_SIZE +: QUAN_SIZE];
                end
            end
        end
    end

    // Registered read data; the page used is the one active before this edge.
    always_ff @(posedge i_write_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_data;
        end
    end

endmodule
